// File: rtl/inverter_pipe.sv
// inverter_pipe: elastic valid/ready pipeline that applies a per-word bitwise
// operation (pass, invert, masked invert, reverse-invert) and counts
// completed output transfers. DEPTH register stages give DEPTH cycles latency.
module inverter_pipe #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_mode,
  input  logic [WIDTH-1:0] in_mask,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] xfer_count
);

  localparam logic [1:0] MODE_PASS    = 2'b00;
  localparam logic [1:0] MODE_INVERT  = 2'b01;
  localparam logic [1:0] MODE_MASKED  = 2'b10;
  localparam logic [1:0] MODE_REV_INV = 2'b11;

  // Mirror a word end to end: result bit i takes source bit WIDTH-1-i.
  function automatic logic [WIDTH-1:0] bit_reverse(input logic [WIDTH-1:0] d);
    logic [WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < WIDTH; i++) begin
      r[i] = d[WIDTH-1-i];
    end
    return r;
  endfunction

  // Selected bitwise operation; the mask only matters for the masked mode.
  function automatic logic [WIDTH-1:0] apply_op(
    input logic [1:0]       mode,
    input logic [WIDTH-1:0] d,
    input logic [WIDTH-1:0] mask
  );
    logic [WIDTH-1:0] r;
    case (mode)
      MODE_PASS:    r = d;
      MODE_INVERT:  r = ~d;
      MODE_MASKED:  r = d ^ mask;
      MODE_REV_INV: r = ~bit_reverse(d);
      default:      r = d;
    endcase
    return r;
  endfunction

  logic [DEPTH-1:0] vld_p;
  logic [WIDTH-1:0] data_p [DEPTH];
  logic [DEPTH-1:0] rdy;
  logic [WIDTH-1:0] op_result;
  logic             out_fire;

  // Operation is evaluated on the input side so stage 0 captures the result.
  always_comb begin
    op_result = apply_op(in_mode, in_data, in_mask);
  end

  // Stage i may load when it, or any stage after it, has a free slot, or the
  // sink is draining. Written as a running AND over the tail of the pipe so
  // the chain has no combinational self-reference.
  always_comb begin
    logic tail_full;
    rdy       = '0;
    tail_full = 1'b1;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      tail_full = tail_full & vld_p[i];
      rdy[i]    = !tail_full || out_ready;
    end
  end

  assign in_ready  = rdy[0] || flush;
  assign out_valid = vld_p[DEPTH-1];
  assign out_data  = data_p[DEPTH-1];
  assign out_fire  = out_valid && out_ready;

  // Stage valid bits: flush empties the pipe; otherwise each ready stage
  // takes its upstream valid so bubbles collapse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p <= '0;
    end else if (flush) begin
      vld_p <= '0;
    end else begin
      if (rdy[0]) begin
        vld_p[0] <= in_valid;
      end
      for (int i = 1; i < DEPTH; i++) begin
        if (rdy[i]) begin
          vld_p[i] <= vld_p[i-1];
        end
      end
    end
  end

  // Stage data: only loaded when a valid word moves in, so a stalled output
  // word stays put; flush leaves stale data behind the cleared valid bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_p[i] <= '0;
      end
    end else begin
      if (rdy[0] && in_valid) begin
        data_p[0] <= op_result;
      end
      for (int i = 1; i < DEPTH; i++) begin
        if (rdy[i] && vld_p[i-1]) begin
          data_p[i] <= data_p[i-1];
        end
      end
    end
  end

  // Completed output handshakes; wraps naturally, cleared by flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xfer_count <= '0;
    end else if (flush) begin
      xfer_count <= '0;
    end else if (out_fire) begin
      xfer_count <= xfer_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_inverter_pipe.sv
// tb_inverter_pipe: scoreboard bench for inverter_pipe (WIDTH=9, DEPTH=2, CNT_W=4).
module tb_inverter_pipe;

  localparam int WIDTH = 9;
  localparam int DEPTH = 2;
  localparam int CNT_W = 4;

  logic             clk;
  logic             rst_n;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [1:0]       in_mode;
  logic [WIDTH-1:0] in_mask;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [CNT_W-1:0] xfer_count;

  int passed = 0;
  int total  = 0;
  logic [WIDTH-1:0] sb_q[$];

  inverter_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_mode(in_mode), .in_mask(in_mask),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .xfer_count(xfer_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [WIDTH-1:0] model(input logic [1:0] m,
                                             input logic [WIDTH-1:0] d,
                                             input logic [WIDTH-1:0] k);
    logic [WIDTH-1:0] rev;
    rev = {<<{d}};
    case (m)
      2'b00:   return d;
      2'b01:   return d ^ {WIDTH{1'b1}};
      2'b10:   return d ^ k;
      default: return rev ^ {WIDTH{1'b1}};
    endcase
  endfunction

  // Scoreboard monitor: compare each output handshake, record each accepted input.
  always @(negedge clk) begin
    logic [WIDTH-1:0] exp_w;
    if (!rst_n) begin
      sb_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        total++;
        if (sb_q.size() == 0) begin
          $display("FAIL scoreboard: unexpected output %h with empty queue", out_data);
        end else begin
          exp_w = sb_q.pop_front();
          if (out_data !== exp_w)
            $display("FAIL scoreboard: out_data=%h want %h", out_data, exp_w);
          else
            passed++;
        end
      end
      if (flush) sb_q.delete();
      else if (in_valid && in_ready) sb_q.push_back(model(in_mode, in_data, in_mask));
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic test_reset();
    #2;
    total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else passed++;
    total++; if (out_data !== '0) $display("FAIL reset_out_data: got %h want 000", out_data); else passed++;
    total++; if (xfer_count !== '0) $display("FAIL reset_count: got %0d want 0", xfer_count); else passed++;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else passed++;
  endtask

  task automatic test_invert_latency();
    logic [WIDTH-1:0] words [2];
    logic [WIDTH-1:0] want  [2];
    words[0] = 9'h00F; want[0] = 9'h1F0;
    words[1] = 9'h1F0; want[1] = 9'h00F;
    out_ready = 1'b1;
    for (int w = 0; w < 2; w++) begin
      in_valid = 1'b1; in_mode = 2'b01; in_data = words[w]; in_mask = 9'($urandom);
      @(posedge clk); #1;
      in_valid = 1'b0;
      total++; if (out_valid !== 1'b0) $display("FAIL latency_early: out_valid=%b want 0", out_valid); else passed++;
      @(posedge clk); #1;
      total++;
      if (out_valid !== 1'b1 || out_data !== want[w])
        $display("FAIL latency_invert: valid=%b data=%h want 1/%h", out_valid, out_data, want[w]);
      else passed++;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [1:0]       modes [3];
    logic [WIDTH-1:0] datas [3];
    logic [WIDTH-1:0] masks [3];
    logic [WIDTH-1:0] want  [3];
    modes[0] = 2'b00; datas[0] = 9'h155; masks[0] = 9'h1A3; want[0] = 9'h155;
    modes[1] = 2'b10; datas[1] = 9'h0FF; masks[1] = 9'h00F; want[1] = 9'h0F0;
    modes[2] = 2'b11; datas[2] = 9'h001; masks[2] = 9'h1FF; want[2] = 9'h0FF;
    out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      if (c < 3) begin
        in_valid = 1'b1; in_mode = modes[c]; in_data = datas[c]; in_mask = masks[c];
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk); #1;
      if (c >= 1 && c <= 3) begin
        total++;
        if (out_valid !== 1'b1 || out_data !== want[c-1])
          $display("FAIL b2b_word%0d: valid=%b data=%h want 1/%h", c - 1, out_valid, out_data, want[c-1]);
        else passed++;
      end
    end
  endtask

  task automatic test_stall();
    logic [WIDTH-1:0] words [3];
    logic [WIDTH-1:0] held;
    int idx;
    words[0] = 9'h0A0; words[1] = 9'h13C; words[2] = 9'h07E;
    held = model(2'b01, words[0], '0);
    idx = 0;
    out_ready = 1'b0;
    in_valid = 1'b1; in_mode = 2'b01; in_data = words[0]; in_mask = '0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (in_valid && in_ready) idx++;
      @(posedge clk); #1;
      if (idx < 3) in_data = words[idx]; else in_valid = 1'b0;
      if (c >= 2) begin
        total++;
        if (out_valid !== 1'b1 || out_data !== held)
          $display("FAIL stall_hold: valid=%b data=%h want 1/%h", out_valid, out_data, held);
        else passed++;
      end
    end
    total++; if (idx != 2) $display("FAIL stall_accepts: got %0d want 2", idx); else passed++;
    total++; if (in_ready !== 1'b0) $display("FAIL stall_in_ready: got %b want 0", in_ready); else passed++;
    out_ready = 1'b1;
    for (int c = 0; c < 20 && !(idx == 3 && sb_q.size() == 0 && !out_valid); c++) begin
      @(negedge clk);
      if (in_valid && in_ready) idx++;
      @(posedge clk); #1;
      if (idx < 3) in_data = words[idx]; else in_valid = 1'b0;
    end
    total++;
    if (idx != 3 || sb_q.size() != 0)
      $display("FAIL stall_drain: accepted=%0d pending=%0d want 3/0", idx, sb_q.size());
    else passed++;
  endtask

  task automatic test_counter_wrap();
    int exp_cnt;
    int sent;
    bit seen15, wrapped;
    out_ready = 1'b1;
    flush = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    flush = 1'b0;
    exp_cnt = 0; sent = 0; seen15 = 0; wrapped = 0;
    in_valid = 1'b1; in_mode = 2'($urandom); in_data = 9'($urandom); in_mask = 9'($urandom);
    for (int c = 0; c < 60 && !(sent == 17 && sb_q.size() == 0 && !out_valid); c++) begin
      @(negedge clk);
      if (out_valid && out_ready) exp_cnt = (exp_cnt + 1) % 16;
      if (in_valid && in_ready) sent++;
      @(posedge clk); #1;
      total++;
      if (xfer_count !== CNT_W'(exp_cnt))
        $display("FAIL count_track: got %0d want %0d", xfer_count, exp_cnt);
      else passed++;
      if (xfer_count == 4'd15) seen15 = 1;
      if (seen15 && xfer_count == 4'd0) wrapped = 1;
      if (sent == 17) in_valid = 1'b0;
      else begin in_mode = 2'($urandom); in_data = 9'($urandom); in_mask = 9'($urandom); end
    end
    total++; if (!wrapped) $display("FAIL count_wrap: saw15=%0d wrapped=%0d want 1/1", seen15, wrapped); else passed++;
    total++; if (xfer_count !== 4'd1) $display("FAIL count_final: got %0d want 1", xfer_count); else passed++;
  endtask

  task automatic test_flush();
    int acc;
    bit leaked;
    acc = 0; leaked = 0;
    out_ready = 1'b0;
    in_valid = 1'b1; in_mode = 2'b00; in_data = 9'h011; in_mask = '0;
    for (int c = 0; c < 10 && acc < 2; c++) begin
      @(negedge clk);
      if (in_valid && in_ready) acc++;
      @(posedge clk); #1;
      in_data = 9'h022;
    end
    total++; if (in_ready !== 1'b0) $display("FAIL flush_full: in_ready=%b want 0", in_ready); else passed++;
    flush = 1'b1; in_valid = 1'b1; in_mode = 2'b00; in_data = 9'h1AA;
    @(negedge clk);
    total++; if (in_ready !== 1'b1) $display("FAIL flush_in_ready: got %b want 1", in_ready); else passed++;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    total++; if (out_valid !== 1'b0) $display("FAIL flush_out_valid: got %b want 0", out_valid); else passed++;
    total++; if (xfer_count !== '0) $display("FAIL flush_count: got %0d want 0", xfer_count); else passed++;
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (out_valid) leaked = 1;
    end
    @(posedge clk); #1;
    total++; if (leaked) $display("FAIL flush_leak: got out_valid=1 want 0 after flush"); else passed++;
  endtask

  task automatic test_async_reset();
    out_ready = 1'b1;
    in_valid = 1'b1; in_mode = 2'b01;
    for (int c = 0; c < 4; c++) begin
      in_data = 9'($urandom);
      @(posedge clk); #1;
    end
    total++; if (out_valid !== 1'b1) $display("FAIL prereset_valid: got %b want 1", out_valid); else passed++;
    #2;
    rst_n = 1'b0; in_valid = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) $display("FAIL areset_valid: got %b want 0", out_valid); else passed++;
    total++; if (out_data !== '0) $display("FAIL areset_data: got %h want 000", out_data); else passed++;
    total++; if (xfer_count !== '0) $display("FAIL areset_count: got %0d want 0", xfer_count); else passed++;
    @(negedge clk);
    @(posedge clk); #2;
    rst_n = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1) $display("FAIL areset_in_ready: got %b want 1", in_ready); else passed++;
    in_valid = 1'b1; in_mode = 2'b11; in_data = 9'h0A5; in_mask = 9'h155;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    total++;
    if (out_valid !== 1'b1 || out_data !== 9'h0B5)
      $display("FAIL areset_first: valid=%b data=%h want 1/0b5", out_valid, out_data);
    else passed++;
    @(posedge clk); #1;
    total++; if (sb_q.size() != 0) $display("FAIL end_queue: pending=%0d want 0", sb_q.size()); else passed++;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0;
    in_mode = 2'b00; in_mask = '0; out_ready = 1'b0;
    test_reset();
    test_invert_latency();
    test_back_to_back();
    test_stall();
    test_counter_wrap();
    test_flush();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
